// File: rtl/abro_pkg.sv
// rtl/abro_pkg.sv - shared types and constants for the ABRO sequence scheduler
//
// Purpose: controller state encoding, detector state constants S0..S3,
//          the TIMEOUT default and an index-width helper.
// Ports:   none (package).

package abro_pkg;

  // Default number of cycles a wait state may spend before aborting.
  localparam int unsigned TIMEOUT_DEFAULT = 16;

  // Detector state values reported on the state bus.
  localparam int unsigned S0 = 0;
  localparam int unsigned S1 = 1;
  localparam int unsigned S2 = 2;
  localparam int unsigned S3 = 3;

  typedef enum logic [3:0] {
    ST_IDLE     = 4'd0,
    ST_DRIVE_AB = 4'd1,
    ST_WAIT_S1  = 4'd2,
    ST_DRIVE_A  = 4'd3,
    ST_WAIT_S2  = 4'd4,
    ST_DRIVE_B  = 4'd5,
    ST_WAIT_S3  = 4'd6,
    ST_WAIT_S0  = 4'd7,
    ST_DONE     = 4'd8,
    ST_ERROR    = 4'd9
  } ctrl_state_t;

  // Width of an index into n entries, never less than one bit.
  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/abro_sched_if.sv
// rtl/abro_sched_if.sv - requester / detector bundle for the ABRO scheduler
//
// Purpose: groups the request/grant lines, detector drive (A, B), detector
//          state feedback and the status outputs.
// Modports:
//   master - environment side: drives req and state, observes the rest.
//   slave  - scheduler side: receives req and state, drives gnt, A, B,
//            done, err, busy, run_count.

interface abro_sched_if #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned SW   = 4
);

  logic [NREQ-1:0] req;
  logic [NREQ-1:0] gnt;
  logic            A;
  logic            B;
  logic [SW-1:0]   state;
  logic            done;
  logic            err;
  logic            busy;
  logic [7:0]      run_count;

  modport master (
    output req, state,
    input  gnt, A, B, done, err, busy, run_count
  );

  modport slave (
    input  req, state,
    output gnt, A, B, done, err, busy, run_count
  );

endinterface

// File: rtl/abro_sched_rr_arbiter.sv
// rtl/abro_sched_rr_arbiter.sv - round-robin arbiter for the ABRO scheduler
//
// Purpose: picks one requester, searching from (last granted + 1) mod NREQ.
// Ports:
//   clk    - clock, rising edge
//   reset  - asynchronous, active-low; pointer returns to NREQ-1 so index 0
//            wins first
//   req    - request vector
//   update - the current winner was accepted; remember it as last granted
//   gnt    - one-hot winner (combinational), zero when req is zero

module rr_arbiter
  import abro_pkg::*;
#(
  parameter int unsigned NREQ = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [NREQ-1:0] req,
  input  logic            update,
  output logic [NREQ-1:0] gnt
);

  localparam int unsigned PW = idx_w(NREQ);

  logic [PW-1:0] ptr_q;
  logic [PW-1:0] win_idx;
  logic          found;

  always_comb begin
    int cand;
    gnt     = '0;
    win_idx = ptr_q;
    found   = 1'b0;
    cand    = 0;
    for (int i = 0; i < int'(NREQ); i++) begin
      // ptr + 1 + i never exceeds 2*NREQ-1, so one wrap is enough.
      cand = int'(ptr_q) + 1 + i;
      if (cand >= int'(NREQ)) cand = cand - int'(NREQ);
      if (!found && req[cand]) begin
        found        = 1'b1;
        win_idx      = PW'(cand);
        gnt[cand]    = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ptr_q <= PW'(NREQ - 1);
    end else if (update && found) begin
      ptr_q <= win_idx;
    end
  end

endmodule

// File: rtl/abro_sched.sv
// rtl/abro_sched.sv - shares one ABRO detector among NREQ requesters
//
// Purpose: grants one requester at a time, walks the detector through
//          AB -> A -> B -> back to S0, and reports done, or err on timeout.
// Ports:
//   clk   - clock, rising edge
//   reset - asynchronous, active-low
//   bus   - abro_sched_if.slave: req in, state in; gnt, A, B (registered),
//           done, err, busy, run_count out

module abro_sched
  import abro_pkg::*;
#(
  parameter int unsigned NREQ    = 4,
  parameter int unsigned SW      = 4,
  parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic         clk,
  input  logic         reset,
  abro_sched_if.slave  bus
);

  localparam int unsigned CW = $clog2(TIMEOUT + 1);

  ctrl_state_t     state_q, state_d;
  logic [CW-1:0]   tmo_q;
  logic [NREQ-1:0] gnt_q;
  logic [NREQ-1:0] arb_gnt;
  logic [7:0]      run_q;
  logic            a_q, b_q, a_d, b_d;
  logic            grant_now;
  logic            in_wait;
  logic            tmo_hit;

  // Only start when the detector is parked in S0; otherwise the sequence
  // would begin from an unknown point.
  assign grant_now = (state_q == ST_IDLE) && (|bus.req) && (bus.state == SW'(S0));
  assign tmo_hit   = (tmo_q == CW'(TIMEOUT));
  assign in_wait   = (state_q == ST_WAIT_S1) || (state_q == ST_WAIT_S2) ||
                     (state_q == ST_WAIT_S3) || (state_q == ST_WAIT_S0);

  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .clk    (clk),
    .reset  (reset),
    .req    (bus.req),
    .update (grant_now),
    .gnt    (arb_gnt)
  );

  // State register; A/B are registered from the next state so they line up
  // with the DRIVE_* states they belong to.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      a_q     <= 1'b0;
      b_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
    end
  end

  // Next-state logic. Out-of-range detector values simply never match.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:     if (grant_now) state_d = ST_DRIVE_AB;
      ST_DRIVE_AB: state_d = ST_WAIT_S1;
      ST_WAIT_S1:  if (bus.state == SW'(S1)) state_d = ST_DRIVE_A;
                   else if (tmo_hit)         state_d = ST_ERROR;
      ST_DRIVE_A:  state_d = ST_WAIT_S2;
      ST_WAIT_S2:  if (bus.state == SW'(S2)) state_d = ST_DRIVE_B;
                   else if (tmo_hit)         state_d = ST_ERROR;
      ST_DRIVE_B:  state_d = ST_WAIT_S3;
      ST_WAIT_S3:  if (bus.state == SW'(S3)) state_d = ST_WAIT_S0;
                   else if (tmo_hit)         state_d = ST_ERROR;
      ST_WAIT_S0:  if (bus.state == SW'(S0)) state_d = ST_DONE;
                   else if (tmo_hit)         state_d = ST_ERROR;
      ST_DONE:     state_d = ST_IDLE;
      ST_ERROR:    state_d = ST_IDLE;
      default:     state_d = ST_IDLE;
    endcase
  end

  // Output logic.
  always_comb begin
    a_d = (state_d == ST_DRIVE_AB) || (state_d == ST_DRIVE_A);
    b_d = (state_d == ST_DRIVE_AB) || (state_d == ST_DRIVE_B);
  end

  // Grant holder, wait-state timer and completion counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      gnt_q <= '0;
      tmo_q <= '0;
      run_q <= 8'd0;
    end else begin
      if (grant_now) begin
        gnt_q <= arb_gnt;
      end else if ((state_q == ST_DONE) || (state_q == ST_ERROR)) begin
        gnt_q <= '0;
      end

      // Any state change restarts the timer, so each wait begins at zero.
      if (state_d != state_q) begin
        tmo_q <= '0;
      end else if (in_wait && !tmo_hit) begin
        tmo_q <= tmo_q + 1'b1;
      end

      if ((state_d == ST_DONE) && (state_q != ST_DONE) && (run_q != 8'hFF)) begin
        run_q <= run_q + 8'd1;
      end
    end
  end

  assign bus.gnt       = gnt_q;
  assign bus.A         = a_q;
  assign bus.B         = b_q;
  assign bus.done      = (state_q == ST_DONE);
  assign bus.err       = (state_q == ST_ERROR);
  assign bus.busy      = (state_q != ST_IDLE);
  assign bus.run_count = run_q;

endmodule

// File: tb/tb_abro_sched.sv
// tb/tb_abro_sched.sv - self-checking bench for abro_sched

module tb_abro_sched;

  logic clk;
  logic reset;

  abro_sched_if #(.NREQ(4), .SW(4)) bus ();

  abro_sched #(.NREQ(4), .SW(4), .TIMEOUT(16)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Detector model: S0 -AB-> S1 -A-> S2 -B-> S3 -> S0.
  logic [3:0] det_q;
  logic       stall, zap, force_en;
  logic [3:0] force_val;

  always @(posedge clk or negedge reset) begin
    if (!reset) det_q <= 4'd0;
    else if (zap) det_q <= 4'd0;
    else if (!stall) begin
      case (det_q)
        4'd0: if (bus.A && bus.B)  det_q <= 4'd1;
        4'd1: if (bus.A && !bus.B) det_q <= 4'd2;
        4'd2: if (bus.B && !bus.A) det_q <= 4'd3;
        4'd3: det_q <= 4'd0;
        default: det_q <= 4'd0;
      endcase
    end
  end

  assign bus.state = force_en ? force_val : det_q;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
  endtask

  // Starts at a negedge in IDLE; returns the grant and done latency
  // (cycles after the grant edge, -1 if done never came).
  task automatic run_txn(input logic [3:0] r, output logic [3:0] g, output int lat);
    int n;
    bus.req = r;
    n = 0;
    while (bus.gnt == 4'b0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    g = bus.gnt;
    bus.req = 4'b0;
    lat = 0;
    while (!bus.done && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    if (!bus.done) lat = -1;
    @(negedge clk);
  endtask

  typedef struct {
    logic [3:0] req;
    logic [3:0] exp_gnt;
    int         exp_count;
  } vec_t;

  vec_t vt[10];
  logic [7:0] trace_exp[9];

  initial begin
    logic [3:0] g;
    int lat;
    int first_err;
    int saw_done;
    int bad;

    vt[0] = '{4'b1111, 4'b0001, 1};
    vt[1] = '{4'b1111, 4'b0010, 2};
    vt[2] = '{4'b1111, 4'b0100, 3};
    vt[3] = '{4'b1111, 4'b1000, 4};
    vt[4] = '{4'b0110, 4'b0010, 5};
    vt[5] = '{4'b0110, 4'b0100, 6};
    vt[6] = '{4'b1001, 4'b1000, 7};
    vt[7] = '{4'b1001, 4'b0001, 8};
    vt[8] = '{4'b0100, 4'b0100, 9};
    vt[9] = '{4'b0101, 4'b0001, 10};

    // {gnt, A, B, done, busy} for cycles 0..8 after the grant edge
    trace_exp = '{8'h1D, 8'h11, 8'h19, 8'h11, 8'h15, 8'h11, 8'h11, 8'h13, 8'h00};

    reset = 1'b0;
    bus.req = 4'b0;
    stall = 1'b0;
    zap = 1'b0;
    force_en = 1'b0;
    force_val = 4'd0;
    repeat (3) @(negedge clk);

    check("rst_gnt",  int'(bus.gnt), 0);
    check("rst_A",    int'(bus.A), 0);
    check("rst_B",    int'(bus.B), 0);
    check("rst_done", int'(bus.done), 0);
    check("rst_err",  int'(bus.err), 0);
    check("rst_busy", int'(bus.busy), 0);
    check("rst_cnt",  int'(bus.run_count), 0);
    reset = 1'b1;
    @(negedge clk);

    // Single request, cycle-by-cycle trace
    bus.req = 4'b0001;
    @(negedge clk);
    bus.req = 4'b0;
    for (int c = 0; c < 9; c++) begin
      check($sformatf("trace_c%0d", c),
            int'({bus.gnt, bus.A, bus.B, bus.done, bus.busy}), int'(trace_exp[c]));
      if (c < 8) @(negedge clk);
    end
    check("single_cnt", int'(bus.run_count), 1);

    // Round-robin table from reset
    do_reset();
    for (int i = 0; i < 10; i++) begin
      run_txn(vt[i].req, g, lat);
      check($sformatf("tbl%0d_gnt", i), int'(g), int'(vt[i].exp_gnt));
      check($sformatf("tbl%0d_lat", i), lat, 7);
      check($sformatf("tbl%0d_cnt", i), int'(bus.run_count), vt[i].exp_count);
    end

    // Detector stuck in S1 -> timeout in WAIT_S2
    bus.req = 4'b0001;
    @(negedge clk);
    check("tmo_gnt", int'(bus.gnt), 1);
    bus.req = 4'b0;
    @(negedge clk);
    stall = 1'b1;
    first_err = -1;
    saw_done = 0;
    for (int c = 2; c <= 21; c++) begin
      @(negedge clk);
      if (bus.err && first_err < 0) first_err = c;
      if (bus.done) saw_done = 1;
    end
    check("tmo_err_cycle", first_err, 20);
    check("tmo_no_done", saw_done, 0);
    check("tmo_err_pulse", int'(bus.err), 0);
    check("tmo_gnt_clr", int'(bus.gnt), 0);
    check("tmo_busy", int'(bus.busy), 0);
    check("tmo_cnt", int'(bus.run_count), 10);
    stall = 1'b0;
    zap = 1'b1;
    @(negedge clk);
    zap = 1'b0;

    // Request while detector is not in S0
    force_en = 1'b1;
    force_val = 4'd2;
    bus.req = 4'b0001;
    repeat (4) @(negedge clk);
    check("s2_no_gnt", int'(bus.gnt), 0);
    check("s2_no_busy", int'(bus.busy), 0);
    force_val = 4'd0;
    @(negedge clk);
    check("s0_gnt", int'(bus.gnt), 1);
    force_en = 1'b0;
    bus.req = 4'b0;
    lat = 0;
    while (!bus.done && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    check("s0_lat", lat, 7);
    @(negedge clk);
    check("s0_cnt", int'(bus.run_count), 11);

    // Reset in the middle of a transaction
    bus.req = 4'b1111;
    @(negedge clk);
    check("mid_gnt", int'(bus.gnt), 2);
    bus.req = 4'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    #1;
    check("mid_rst_outs",
          int'({bus.gnt, bus.A, bus.B, bus.done, bus.err, bus.busy, bus.run_count}), 0);
    saw_done = 0;
    repeat (2) begin
      @(negedge clk);
      if (bus.done || bus.err) saw_done = 1;
    end
    check("mid_rst_no_pulse", saw_done, 0);
    reset = 1'b1;
    @(negedge clk);
    run_txn(4'b1111, g, lat);
    check("post_rst_gnt", int'(g), 1);
    check("post_rst_lat", lat, 7);

    // Saturation of run_count
    do_reset();
    bad = 0;
    for (int i = 0; i < 254; i++) begin
      run_txn(4'b1111, g, lat);
      if (lat != 7) bad++;
    end
    check("sat_254", int'(bus.run_count), 254);
    run_txn(4'b1111, g, lat);
    if (lat != 7) bad++;
    check("sat_255", int'(bus.run_count), 255);
    for (int i = 0; i < 5; i++) begin
      run_txn(4'b1111, g, lat);
      if (lat != 7) bad++;
    end
    check("sat_260", int'(bus.run_count), 255);
    check("sat_lat_bad", bad, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/abro_sched.md
ABRO_SCHED -- requirements
Module: abro_sched

Interface
REQ-001 The block SHALL have parameter NREQ, default 4, number of requesters sharing one ABRO detector.
REQ-002 The block SHALL have parameter SW, default 4, width of the detector state bus.
REQ-003 The block SHALL have parameter TIMEOUT, default 16, max cycles spent in any wait state.
REQ-004 The block SHALL have port clk  input  1  clock, rising edge.
REQ-005 The block SHALL have port reset  input  1  reset, asynchronous, active-low.
REQ-006 The block SHALL have port req  input  NREQ  per-requester sequence request, level.
REQ-007 The block SHALL have port gnt  output  NREQ  one-hot grant, held for the whole transaction.
REQ-008 The block SHALL have port A  output  1  detector input A, registered.
REQ-009 The block SHALL have port B  output  1  detector input B, registered.
REQ-010 The block SHALL have port state  input  SW  detector current state (0,1,2,3 valid).
REQ-011 The block SHALL have port done  output  1  one-cycle pulse, sequence completed.
REQ-012 The block SHALL have port err  output  1  one-cycle pulse, sequence aborted on timeout.
REQ-013 The block SHALL have port busy  output  1  high in every controller state except IDLE.
REQ-014 The block SHALL have port run_count  output  8  completed sequences, saturating at 255.

Function
REQ-015 Controller states SHALL be IDLE, DRIVE_AB, WAIT_S1, DRIVE_A, WAIT_S2, DRIVE_B, WAIT_S3, WAIT_S0, DONE, ERROR.
REQ-016 IDLE: when any req bit is high and state==0, the block SHALL load gnt with the round-robin winner and enter DRIVE_AB on the same edge; if state!=0 it SHALL stay in IDLE with gnt=0.
REQ-017 Round-robin: search SHALL start at index (last granted + 1) mod NREQ; after reset, index 0 has highest priority.
REQ-018 DRIVE_AB SHALL last one cycle with A=1,B=1, then go to WAIT_S1; DRIVE_A one cycle A=1,B=0 then WAIT_S2; DRIVE_B one cycle A=0,B=1 then WAIT_S3.
REQ-019 In all other states, A and B SHALL be 0.
REQ-020 WAIT_S1 SHALL go to DRIVE_A when state==1; WAIT_S2 to DRIVE_B when state==2; WAIT_S3 to WAIT_S0 when state==3; WAIT_S0 to DONE when state==0.
REQ-021 A timeout counter SHALL clear on entry to each WAIT state; if it reaches TIMEOUT before the expected state is seen, the block SHALL enter ERROR.
REQ-022 DONE and ERROR SHALL each last one cycle, then go to IDLE; done=1 only in DONE, err=1 only in ERROR; gnt SHALL clear on the edge leaving DONE/ERROR.
REQ-023 Nominal latency: done SHALL be high in cycle 7 after the grant edge (grant edge = cycle 0).
REQ-024 A requester dropping req mid-transaction SHALL NOT abort it; new req edges during a transaction SHALL be evaluated only in IDLE.
REQ-025 run_count SHALL increment on each DONE, SHALL hold at 255, and SHALL NOT change on ERROR.
REQ-026 state values outside 0..3 SHALL be treated as "not expected" (timeout path applies).

Reset
REQ-027 On reset low: controller IDLE, gnt=0, A=0, B=0, done=0, err=0, busy=0, run_count=0, timeout counter=0, round-robin pointer to index NREQ-1.
REQ-028 Reset asserted mid-transaction SHALL abort immediately with no done or err pulse.

Structure
REQ-029 Controller state enum, detector state constants S0..S3, and TIMEOUT default SHALL live in shared package abro_pkg.
REQ-030 Round-robin selection SHALL be a sub-module rr_arbiter (req, pointer update on grant, one-hot gnt out).

Verification
REQ-031 Single request req=4'b0001, detector model normal -> gnt=0001 at cycle 0, A=B=1 cycle 0, A=1 cycle 2, B=1 cycle 4, done at cycle 7, run_count=1.
REQ-032 req=4'b1111 held for 4 transactions -> gnt order 0001,0010,0100,1000; run_count=4.
REQ-033 Detector stalled in state 1 -> err pulse 17 cycles after entry to WAIT_S2 (TIMEOUT=16), gnt cleared, run_count unchanged.
REQ-034 req=0001 while detector state==2 -> gnt stays 0 until state==0, then grant next edge.
REQ-035 Reset low at cycle 3 of a transaction -> all outputs 0 same cycle, no done/err; next transaction after reset grants index 0 first.
REQ-036 run_count preset via 260 back-to-back sequences -> saturates at 255.
